muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller beside the main ALU in the execute stage.
- Accepts one operation per start handshake and sequences 32 shift-add (multiply) or restoring-subtract (divide) steps, one step per cycle.
- Produces HI/LO results and a busy signal that the hazard unit uses to stall the pipeline.
- Operands arrive from the forwarded rdat1/rdat2 paths.

Parameters:
- WIDTH, 32, operand/result word width; must equal word_t width.
- CNT_W, 5, iteration counter width; equals clog2(WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  muldiv_op_t: MULTU=00, DIVU=01, MULT=10, DIV=11.
- opa  input  WIDTH  multiplicand / dividend.
- opb  input  WIDTH  multiplier / divisor.
- flush  input  1  abort in-flight operation (branch/exception squash).
- busy  output  1  high while an operation is in flight; drives the pipeline stall.
- done  output  1  one-cycle pulse when hi/lo update.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.

Interface rule:
- One clock, CLK.
- Reset is asynchronous and active-low, nRST.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 latches op, opa, opb and goes to CALC with counter=WIDTH-1; busy rises the next cycle.
  - start=0: stay in IDLE.
- CALC:
  - Performs one iteration per cycle and decrements the counter.
  - counter==0 in CALC goes to FIN on the next edge.
- Multiply step (WIDTH+1-bit accumulator):
  - If multiplier LSB=1, add multiplicand to the upper half.
  - Then shift {acc, multiplier} right by 1.
- Divide step (restoring):
  - Shift {rem, quot} left by 1.
  - rem -= divisor; if the result is negative, restore rem and set quot LSB=0, else set it to 1.
- FIN:
  - Registers hi/lo from the accumulators.
  - done=1 for exactly this cycle; busy=0 in this cycle.
  - Next state is IDLE.
- Latency: start accepted at edge N → done high in cycle N+WIDTH+1 (33 cycles for WIDTH=32); hi/lo are valid from that cycle on.
- busy is high for cycles N+1 … N+WIDTH.
- start while busy: ignored; the in-flight operation is not disturbed.
- start in the FIN cycle: ignored; the next request is accepted from IDLE.
- Divide by zero (opb==0, DIVU or DIV): skips CALC and goes IDLE→FIN; hi=opa, lo=all ones; done one cycle after start.
- flush: in CALC or FIN, return to IDLE on the next edge; hi/lo keep their previous values; done is suppressed.
- flush in IDLE is ignored. flush together with start in IDLE: flush wins, nothing is launched.
- nRST low mid-operation: immediate return to reset values; no done pulse.
- hi/lo hold their values between completions.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - MULT/DIV take operand magnitudes at launch and run the unsigned core.
  - The result is negated at FIN when the signs differ (product, quotient); the remainder takes the dividend's sign.
  - Signed divide by zero gives the same result as unsigned.
- Undefined: op[1] is ignored; MULT behaves as MULTU and DIV as DIVU.

Decomposition:
- Add to cpu_types_pkg:
  - muldiv_op_t enum (2 bits).
  - muldiv_state_t enum (IDLE, CALC, FIN).
  - Constant MULDIV_LATENCY = WIDTH+1.
- Interface: muldiv_if with modports md (block) and tb (bench).
- Sub-module: muldiv_step, the combinational single-iteration datapath (mult add/shift, div subtract/restore) selected by op. The FSM, counter and registers stay in muldiv_sequencer.

Test Plan:
- MULTU opa=7, opb=6, start 1 cycle → busy 32 cycles, done in cycle 33, hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2 after 33 cycles.
- DIVU 0x12345678/0 → done one cycle after start, hi=0x12345678, lo=0xFFFFFFFF.
- Overlap and abort:
  - Second start with different operands during busy → ignored; first result unchanged.
  - flush at iteration 10 → IDLE next cycle, no done, hi/lo keep their prior values.
  - nRST pulse mid-CALC → busy=0, hi=lo=0 immediately.
- With MULDIV_SIGNED_EN: MULT −3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Without the macro: MULT −3×5 → hi=0x00000004, lo=0xFFFFFFF1 (unsigned).

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: word type, mul/div opcode and sequencer state
// encodings, and the fixed start-to-done latency of the iterative mul/div unit.
package cpu_types_pkg;

    localparam int WORD_W         = 32;
    localparam int MULDIV_CNT_W   = $clog2(WORD_W);
    // Cycles from the accepting edge to the done pulse (WIDTH steps + FIN).
    localparam int MULDIV_LATENCY = WORD_W + 1;

    typedef logic [WORD_W-1:0] word_t;

    // Bit 0 selects divide, bit 1 selects signed.
    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MULT  = 2'b10,
        MD_DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the mul/div sequencer request/result signals; md is the block
// side, tb the requester side.
interface muldiv_if;
    import cpu_types_pkg::*;

    logic       start;
    logic [1:0] op;
    word_t      opa;
    word_t      opb;
    logic       flush;
    logic       busy;
    logic       done;
    word_t      hi;
    word_t      lo;

    modport md (input start, op, opa, opb, flush, output busy, done, hi, lo);
    modport tb (output start, op, opa, opb, flush, input busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned mul/div core.
// Multiply: {acc, lo} holds {partial product, remaining multiplier bits}.
// Divide:   {acc, lo} holds {partial remainder, dividend/quotient bits}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Shift-add for multiply, shift-subtract-restore for divide.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave it
        // unassigned and infer a latch.
        acc_out = acc_in;
        lo_out  = lo_in;

        sum    = acc_in + (lo_in[0] ? {1'b0, b_in} : {(WIDTH+1){1'b0}});
        rem_sh = {acc_in[WIDTH-1:0], lo_in[WIDTH-1]};
        // One extra bit so the borrow shows up as the sign.
        diff   = {1'b0, rem_sh} - {2'b00, b_in};

        if (is_div) begin
            if (diff[WIDTH+1]) begin
                acc_out = rem_sh;
                lo_out  = {lo_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = diff[WIDTH:0];
                lo_out  = {lo_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {1'b0, sum[WIDTH:1]};
            lo_out  = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer: one start handshake launches WIDTH
// shift-add / restoring-subtract steps, then a FIN cycle that publishes HI/LO
// with a one-cycle done pulse. busy stalls the pipeline while CALC runs.
// Optional macro MULDIV_SIGNED_EN: MULT/DIV run on operand magnitudes and
// fix the result signs at FIN; without it op[1] has no effect.
module muldiv_sequencer
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = MULDIV_CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .lo_in   (lo_acc_q),
        .b_in    (b_q),
        .acc_out (step_acc),
        .lo_out  (step_lo)
    );

    // Launch operands as magnitudes; sign handling is a no-op when unsigned.
    always_comb begin
        a_neg = SIGNED_EN && op[1] && opa[WIDTH-1];
        b_neg = SIGNED_EN && op[1] && opb[WIDTH-1];
        a_mag = a_neg ? -opa : opa;
        b_mag = b_neg ? -opb : opb;
    end

    // Final HI/LO from the accumulators, with the sign correction applied.
    always_comb begin
        prod   = {acc_q[WIDTH-1:0], lo_acc_q};
        fin_hi = acc_q[WIDTH-1:0];
        fin_lo = lo_acc_q;
        if (!is_div_q) begin
            if (neg_res_q) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            if (neg_res_q) fin_lo = -lo_acc_q;
            if (neg_rem_q) fin_hi = -acc_q[WIDTH-1:0];
        end
    end

    // FSM next state, iteration counter and datapath register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_acc_d  = lo_acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                // flush beats start: a squashed request never launches.
                if (start && !flush) begin
                    is_div_d = op[0];
                    b_d      = b_mag;
                    if (op[0] && (opb == '0)) begin
                        // Divide by zero: present hi=opa, lo=all ones at FIN.
                        acc_d     = {1'b0, opa};
                        lo_acc_d  = '1;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = FIN;
                    end else begin
                        acc_d     = '0;
                        lo_acc_d  = a_mag;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = step_acc;
                    lo_acc_d = step_lo;
                    if (cnt_q == '0) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = fin_hi;
                    lo_d = fin_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_acc_q  <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lo_acc_q  <= lo_acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // During FIN the new result is already visible; a flush hides it.
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == FIN) && !flush;
        hi   = done ? fin_hi : hi_q;
        lo   = done ? fin_lo : lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed products, quotients,
// divide-by-zero, overlap, flush and mid-operation reset.
module tb_muldiv_sequencer;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_sequencer dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and watch 45 cycles. Optionally inject a second
    // start at cycle intr_at, a flush at cycle flush_at, or a start during
    // the done cycle. Cycle i is the i-th cycle after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int intr_at, input int flush_at, input bit fin_start,
                          output int lat, output int bcnt, output int dcnt,
                          output logic bz, output logic [31:0] rh, output logic [31:0] rl);
        lat  = 0;
        bcnt = 0;
        dcnt = 0;
        bz   = 1'b1;
        rh   = '0;
        rl   = '0;
        @(negedge CLK);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = i;
                    bz  = busy;
                    rh  = hi;
                    rl  = lo;
                end
            end
            if (busy) bcnt++;
            start = (i == intr_at) || (fin_start && done);
            if (i == intr_at) begin
                op  = 2'b01;
                opa = 32'd100;
                opb = 32'd7;
            end
            flush = (i == flush_at);
            @(negedge CLK);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    int          lat, bcnt, dcnt;
    logic        bz;
    logic [31:0] rh, rl;

    initial begin
        nRST  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        flush = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        nRST = 1'b1;

        // MULTU 7*6, plus a start in the done cycle that must be ignored.
        run_op(2'b00, 32'd7, 32'd6, 0, 0, 1'b1, lat, bcnt, dcnt, bz, rh, rl);
        check("mul7x6_lat", lat, 33);
        check("mul7x6_busy", bcnt, 32);
        check("mul7x6_busy_at_done", bz, 0);
        check("mul7x6_done_cnt", dcnt, 1);
        check("mul7x6_hi", rh, 32'h0000_0000);
        check("mul7x6_lo", rl, 32'h0000_002A);
        check("mul7x6_hold_hi", hi, 32'h0000_0000);
        check("mul7x6_hold_lo", lo, 32'h0000_002A);

        // MULTU max*max.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("mulmax_lat", lat, 33);
        check("mulmax_hi", rh, 32'hFFFF_FFFE);
        check("mulmax_lo", rl, 32'h0000_0001);

        // DIVU 100/7.
        run_op(2'b01, 32'd100, 32'd7, 0, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("div100_lat", lat, 33);
        check("div100_busy", bcnt, 32);
        check("div100_hi", rh, 32'd2);
        check("div100_lo", rl, 32'd14);

        // DIVU by zero: straight to FIN.
        run_op(2'b01, 32'h1234_5678, 32'd0, 0, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("divz_lat", lat, 1);
        check("divz_busy", bcnt, 0);
        check("divz_done_cnt", dcnt, 1);
        check("divz_hi", rh, 32'h1234_5678);
        check("divz_lo", rl, 32'hFFFF_FFFF);

        // A second start mid-operation must not disturb MULTU 7*6.
        run_op(2'b00, 32'd7, 32'd6, 5, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("ovl_lat", lat, 33);
        check("ovl_busy", bcnt, 32);
        check("ovl_done_cnt", dcnt, 1);
        check("ovl_hi", rh, 32'h0000_0000);
        check("ovl_lo", rl, 32'h0000_002A);

        // Flush at iteration 10: no done, result registers untouched.
        run_op(2'b01, 32'd100, 32'd7, 0, 10, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("flush_busy", bcnt, 10);
        check("flush_done_cnt", dcnt, 0);
        check("flush_hi", hi, 32'h0000_0000);
        check("flush_lo", lo, 32'h0000_002A);

        // flush together with start in IDLE launches nothing.
        @(negedge CLK);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        opa   = 32'd3;
        opb   = 32'd3;
        @(negedge CLK);
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", busy, 0);
        check("idle_flush_done", done, 0);
        @(negedge CLK);
        check("idle_flush_busy2", busy, 0);

        // MULT -3*5.
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("mult_lat", lat, 33);
`ifdef MULDIV_SIGNED_EN
        check("mult_hi", rh, 32'hFFFF_FFFF);
        check("mult_lo", rl, 32'hFFFF_FFF1);
`else
        check("mult_hi", rh, 32'h0000_0004);
        check("mult_lo", rl, 32'hFFFF_FFF1);
`endif

        // DIV -7/2.
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, lat, bcnt, dcnt, bz, rh, rl);
        check("sdiv_lat", lat, 33);
`ifdef MULDIV_SIGNED_EN
        check("sdiv_hi", rh, 32'hFFFF_FFFF);
        check("sdiv_lo", rl, 32'hFFFF_FFFD);
`else
        check("sdiv_hi", rh, 32'h0000_0001);
        check("sdiv_lo", rl, 32'h7FFF_FFFC);
`endif

        // Reset pulse in the middle of CALC clears everything at once.
        @(negedge CLK);
        start = 1'b1;
        op    = 2'b00;
        opa   = 32'd9;
        opb   = 32'd9;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        check("mid_busy_before_rst", busy, 1);
        nRST = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (done || busy) break;
        end
        check("post_rst_quiet", {busy, done}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
